// File: rtl/display_render_ctrl.sv
// Raster renderer: walks an H_RES x V_RES frame and emits one registered
// (x, y, colour, plot) tuple per enabled scan cycle. Game inputs are captured
// once per frame in LOAD so a frame never mixes old and new object state.

// Square window hit test for one object: |px-ox|<=R and |py-oy|<=R, using
// one-bit-wider signed differences so objects near 0 or max never wrap.
module render_win_hit #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int R  = 1
) (
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] py,
    input  logic [XW-1:0] ox,
    input  logic [YW-1:0] oy,
    output logic          hit
);
    localparam logic signed [XW:0] RX = R[XW:0];
    localparam logic signed [YW:0] RY = R[YW:0];

    logic signed [XW:0] dx;
    logic signed [YW:0] dy;

    assign dx  = $signed({1'b0, px}) - $signed({1'b0, ox});
    assign dy  = $signed({1'b0, py}) - $signed({1'b0, oy});
    assign hit = (dx >= -RX) && (dx <= RX) && (dy >= -RY) && (dy <= RY);
endmodule

module display_render_ctrl #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int XW     = 8,
    parameter int YW     = 7,
    parameter int N_BALL = 8,
    parameter int N_MON  = 4,
    parameter int BALL_R = 1,
    parameter int MON_R  = 3,
    parameter int GUN_R  = 5,
    parameter int BORDER = 10,
    parameter int GUN_X  = 80,
    parameter int GUN_Y  = 60
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             disp_state,
    input  logic [1:0]             gun_dir,
    input  logic [N_MON-1:0]       size_monster,
    input  logic [N_MON*XW-1:0]    monster_pos_x_vector,
    input  logic [N_MON*YW-1:0]    monster_pos_y_vector,
    input  logic [N_BALL*XW-1:0]   ball_x_vector,
    input  logic [N_BALL*YW-1:0]   ball_y_vector,
    input  logic [N_BALL-1:0]      ball_valid,
    output logic [2:0]             colour,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic                   plot,
    output logic                   frame_start,
    output logic                   frame_done
);
    localparam int XL_I = H_RES - 1;
    localparam int YL_I = V_RES - 1;
    localparam int XH_I = H_RES - 1 - BORDER;
    localparam int YH_I = V_RES - 1 - BORDER;
    localparam int BRL_I = 2;
    localparam logic [XW-1:0] X_LAST = XL_I[XW-1:0];
    localparam logic [YW-1:0] Y_LAST = YL_I[YW-1:0];
    localparam logic [XW-1:0] X_LO   = BORDER[XW-1:0];
    localparam logic [YW-1:0] Y_LO   = BORDER[YW-1:0];
    localparam logic [XW-1:0] X_HI   = XH_I[XW-1:0];
    localparam logic [YW-1:0] Y_HI   = YH_I[YW-1:0];
    localparam logic [XW-1:0] GX     = GUN_X[XW-1:0];
    localparam logic [YW-1:0] GY     = GUN_Y[YW-1:0];
    localparam logic signed [XW:0] GRX   = GUN_R[XW:0];
    localparam logic signed [YW:0] GRY   = GUN_R[YW:0];
    localparam logic signed [XW:0] BRL_X = BRL_I[XW:0];
    localparam logic signed [YW:0] BRL_Y = BRL_I[YW:0];

    typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;
    state_t state_q, state_d;

    logic           load, scan_adv, last_px;
    logic [XW-1:0]  cx;
    logic [YW-1:0]  cy;

    // Per-frame snapshot; packed slot 0 sits in the MSBs like the input vectors
    logic [3:0]                  mode_s;
    logic [1:0]                  dir_s;
    logic [N_MON-1:0]            msize_s;
    logic [N_MON-1:0][XW-1:0]    mx_s;
    logic [N_MON-1:0][YW-1:0]    my_s;
    logic [N_BALL-1:0][XW-1:0]   bx_s;
    logic [N_BALL-1:0][YW-1:0]   by_s;
    logic [N_BALL-1:0]           bv_s;

    logic [N_BALL-1:0] ball_hit;
    logic [N_MON-1:0]  mon_hit;
    logic signed [XW:0] gdx;
    logic signed [YW:0] gdy;
    logic in_play, in_gun, gun_body, gun_barrel;
    logic [2:0] mon_col, game_col, pix_col;

    assign last_px = (cx == X_LAST) && (cy == Y_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: LOAD is a single capture cycle between frames
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        scan_adv = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = LOAD;
            LOAD: begin
                load    = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (enable) begin
                scan_adv = 1'b1;
                if (last_px) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture every game input once per frame
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_s <= '0; dir_s <= '0; msize_s <= '0;
            mx_s <= '0; my_s <= '0; bx_s <= '0; by_s <= '0; bv_s <= '0;
        end else if (load) begin
            mode_s  <= disp_state;
            dir_s   <= gun_dir;
            msize_s <= size_monster;
            mx_s    <= monster_pos_x_vector;
            my_s    <= monster_pos_y_vector;
            bx_s    <= ball_x_vector;
            by_s    <= ball_y_vector;
            bv_s    <= ball_valid;
        end
    end

    // Raster counter; holds whenever enable is low
    always_ff @(posedge clock) begin
        if (reset || load) begin
            cx <= '0;
            cy <= '0;
        end else if (scan_adv) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= last_px ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BALL; gi++) begin : g_ball
            render_win_hit #(.XW(XW), .YW(YW), .R(BALL_R)) u_hit (
                .px(cx), .py(cy),
                .ox(bx_s[N_BALL-1-gi]), .oy(by_s[N_BALL-1-gi]),
                .hit(ball_hit[gi])
            );
        end
        for (gi = 0; gi < N_MON; gi++) begin : g_mon
            render_win_hit #(.XW(XW), .YW(YW), .R(MON_R)) u_hit (
                .px(cx), .py(cy),
                .ox(mx_s[N_MON-1-gi]), .oy(my_s[N_MON-1-gi]),
                .hit(mon_hit[gi])
            );
        end
    endgenerate

    assign gdx = $signed({1'b0, cx}) - $signed({1'b0, GX});
    assign gdy = $signed({1'b0, cy}) - $signed({1'b0, GY});

    // Pixel colour: border, gun, balls, monsters in priority order, then mode select.
    // The gun body fills the half of its window facing gun_dir, and the barrel
    // strip runs through the centre along the gun_dir axis.
    always_comb begin
        in_play = (cx >= X_LO) && (cx <= X_HI) && (cy >= Y_LO) && (cy <= Y_HI);
        in_gun  = (gdx >= -GRX) && (gdx <= GRX) && (gdy >= -GRY) && (gdy <= GRY);
        case (dir_s)
            2'd0:    gun_body = gdx[XW] || (gdx == '0);
            2'd1:    gun_body = !gdy[YW];
            2'd2:    gun_body = !gdx[XW];
            default: gun_body = gdy[YW] || (gdy == '0);
        endcase
        gun_barrel = dir_s[0] ? ((gdx >= -BRL_X) && (gdx <= BRL_X))
                              : ((gdy >= -BRL_Y) && (gdy <= BRL_Y));
        mon_col = 3'b000;
        for (int j = N_MON-1; j >= 0; j--)
            if (mon_hit[j]) mon_col = msize_s[j] ? 3'b100 : 3'b001;
        if (!in_play)                  game_col = 3'b000;
        else if (in_gun)               game_col = (gun_body || gun_barrel) ? 3'b100 : 3'b000;
        else if (|(ball_hit & bv_s))   game_col = 3'b010;
        else                           game_col = mon_col;
        case (mode_s)
            4'b0010: pix_col = game_col;
            4'b0100: pix_col = 3'b010;
            4'b1000: pix_col = 3'b100;
            default: pix_col = 3'b000;
        endcase
    end

    // Output stage: one register, all outputs leave together
    always_ff @(posedge clock) begin
        if (reset) begin
            colour <= '0; x <= '0; y <= '0;
            plot <= 1'b0; frame_start <= 1'b0; frame_done <= 1'b0;
        end else begin
            plot        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (scan_adv) begin
                x           <= cx;
                y           <= cy;
                colour      <= pix_col;
                plot        <= 1'b1;
                frame_start <= (cx == '0) && (cy == '0);
                frame_done  <= last_px;
            end
        end
    end
endmodule

// File: tb/tb_display_render_ctrl.sv
// Self-checking bench for display_render_ctrl: every plotted pixel is compared
// with a per-pixel colour model evaluated on the frame's captured game state.
module tb_display_render_ctrl;
    localparam int H = 160, V = 120, XW = 8, YW = 7, NB = 8, NM = 4;

    logic clock = 1'b0;
    logic reset, enable;
    logic [3:0] disp_state;
    logic [1:0] gun_dir;
    logic [NM-1:0] size_monster;
    logic [NM*XW-1:0] monster_pos_x_vector;
    logic [NM*YW-1:0] monster_pos_y_vector;
    logic [NB*XW-1:0] ball_x_vector;
    logic [NB*YW-1:0] ball_y_vector;
    logic [NB-1:0] ball_valid;
    logic [2:0] colour;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic plot, frame_start, frame_done;

    always #5 clock = ~clock;

    display_render_ctrl dut (
        .clock(clock), .reset(reset), .enable(enable),
        .disp_state(disp_state), .gun_dir(gun_dir), .size_monster(size_monster),
        .monster_pos_x_vector(monster_pos_x_vector),
        .monster_pos_y_vector(monster_pos_y_vector),
        .ball_x_vector(ball_x_vector), .ball_y_vector(ball_y_vector),
        .ball_valid(ball_valid),
        .colour(colour), .x(x), .y(y), .plot(plot),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    int checks = 0, failures = 0;
    int cur_mode, cur_dir, snap_mode, snap_dir;
    int cur_bx[NB], cur_by[NB], cur_bv[NB], snap_bx[NB], snap_by[NB], snap_bv[NB];
    int cur_mx[NM], cur_my[NM], cur_ms[NM], snap_mx[NM], snap_my[NM], snap_ms[NM];
    logic [2:0] fb [H][V];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Colour of one pixel from the screen rules, using the captured state
    function automatic int ref_colour(input int px, input int py);
        int dx, dy;
        bit body, barrel;
        if (snap_mode == 4) return 2;
        if (snap_mode == 8) return 4;
        if (snap_mode != 2) return 0;
        if (px < 10 || px > H-11 || py < 10 || py > V-11) return 0;
        dx = px - 80;
        dy = py - 60;
        if (iabs(dx) <= 5 && iabs(dy) <= 5) begin
            body = (snap_dir == 0 && dx <= 0) || (snap_dir == 2 && dx >= 0) ||
                   (snap_dir == 1 && dy >= 0) || (snap_dir == 3 && dy <= 0);
            barrel = (snap_dir == 0 || snap_dir == 2) ? (iabs(dy) <= 2) : (iabs(dx) <= 2);
            return (body || barrel) ? 4 : 0;
        end
        for (int i = 0; i < NB; i++)
            if (snap_bv[i] != 0 && iabs(px - snap_bx[i]) <= 1 && iabs(py - snap_by[i]) <= 1)
                return 2;
        for (int j = 0; j < NM; j++)
            if (iabs(px - snap_mx[j]) <= 3 && iabs(py - snap_my[j]) <= 3)
                return (snap_ms[j] != 0) ? 4 : 1;
        return 0;
    endfunction

    task automatic drive();
        disp_state = 4'(cur_mode);
        gun_dir    = 2'(cur_dir);
        for (int i = 0; i < NB; i++) begin
            ball_x_vector[(NB-1-i)*XW +: XW] = XW'(cur_bx[i]);
            ball_y_vector[(NB-1-i)*YW +: YW] = YW'(cur_by[i]);
            ball_valid[i] = cur_bv[i][0];
        end
        for (int j = 0; j < NM; j++) begin
            monster_pos_x_vector[(NM-1-j)*XW +: XW] = XW'(cur_mx[j]);
            monster_pos_y_vector[(NM-1-j)*YW +: YW] = YW'(cur_my[j]);
            size_monster[j] = cur_ms[j][0];
        end
    endtask

    task automatic take_snap();
        snap_mode = cur_mode;
        snap_dir  = cur_dir;
        for (int i = 0; i < NB; i++) begin
            snap_bx[i] = cur_bx[i]; snap_by[i] = cur_by[i]; snap_bv[i] = cur_bv[i];
        end
        for (int j = 0; j < NM; j++) begin
            snap_mx[j] = cur_mx[j]; snap_my[j] = cur_my[j]; snap_ms[j] = cur_ms[j];
        end
    endtask

    task automatic step(input logic en, input logic rst);
        enable = en;
        reset  = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_colour"}, colour, 0);
        check({tag, "_fstart"}, frame_start, 0);
        check({tag, "_fdone"}, frame_done, 0);
    endtask

    // One full frame; inputs change at row change_row (kind 1: enter game
    // mode, kind 2: turn gun up, hide ball 0, move other balls).
    task automatic run_frame(input int toggle_rows, input int change_row, input int kind);
        int ex = 0, ey = 0, n = 0, cyc = 0;
        bit done = 0;
        logic en;
        take_snap();
        while (!done && cyc < 45000) begin
            en = (ey < toggle_rows) ? logic'(cyc[0]) : 1'b1;
            step(en, 1'b0);
            cyc++;
            if (!en) begin
                check("stall_plot", plot, 0);
            end else if (plot) begin
                check("px_x", x, ex);
                check("px_y", y, ey);
                check("px_colour", colour, ref_colour(ex, ey));
                check("px_fstart", frame_start, (ex == 0 && ey == 0));
                check("px_fdone", frame_done, (ex == H-1 && ey == V-1));
                fb[ex][ey] = colour;
                n++;
                if (ex == H-1 && ey == V-1) done = 1;
                if (ex == H-1) begin
                    ex = 0;
                    ey++;
                    if (ey == change_row) begin
                        if (kind == 1) cur_mode = 2;
                        else begin
                            cur_dir = 3;
                            cur_bv[0] = 0;
                            for (int i = 1; i < NB; i++) cur_bx[i] = $urandom_range(159, 90);
                        end
                        drive();
                    end
                end else begin
                    ex++;
                end
            end
        end
        if (!done) check("frame_timeout", 0, 1);
        else       check("plot_count", n, H*V);
    endtask

    initial begin
        int waited;
        // Directed objects plus randomized ones kept clear of the gun and of ball/monster 0
        cur_mode = 4; cur_dir = 0;
        cur_bx[0] = 30; cur_by[0] = 30; cur_bv[0] = 1;
        for (int i = 1; i < NB; i++) begin
            cur_bx[i] = $urandom_range(159, 90);
            cur_by[i] = $urandom_range(119, 0);
            cur_bv[i] = $urandom_range(1, 0);
        end
        cur_mx[0] = 30; cur_my[0] = 30; cur_ms[0] = 1;
        cur_mx[1] = 2;  cur_my[1] = 2;  cur_ms[1] = $urandom_range(1, 0);
        for (int j = 2; j < NM; j++) begin
            cur_mx[j] = $urandom_range(159, 90);
            cur_my[j] = $urandom_range(119, 0);
            cur_ms[j] = $urandom_range(1, 0);
        end
        drive();

        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        check_outputs_zero("reset");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check("idle_plot", plot, 0);
        end

        // Frame A: mode 0100; switch to game mode mid-frame (must not show yet)
        run_frame(0, 60, 1);
        check("A_first_colour", fb[0][0], 3'b010);

        // Frame B: game composition, gun left
        run_frame(0, 60, 2);
        check("B_gun_75_60", fb[75][60], 3'b100);
        check("B_gun_85_60", fb[85][60], 3'b100);
        check("B_gun_85_57", fb[85][57], 3'b000);
        check("B_ball_wins", fb[31][31], 3'b010);
        check("B_mon_red", fb[33][33], 3'b100);
        check("B_mon1_self", fb[2][2], 3'b000);
        check("B_inside_border", fb[12][12], 3'b000);
        check("B_no_wrap_x", fb[158][5], 3'b000);
        check("B_no_wrap_y", fb[4][118], 3'b000);
        check("B_no_wrap_xy", fb[159][119], 3'b000);

        // Frame C: new state visible; enable toggled for the first rows
        run_frame(10, -1, 0);
        check("C_gun_up_80_55", fb[80][55], 3'b100);
        check("C_gun_up_77_65", fb[77][65], 3'b000);
        check("C_ball_hidden", fb[31][31], 3'b100);

        // Frame D: reset at pixel (50,40), then restart with a new mode
        waited = 0;
        while (!(plot && x == 50 && y == 40) && waited < 20000) begin
            step(1'b1, 1'b0);
            waited++;
        end
        check("D_reach_50_40", waited < 20000, 1);
        cur_mode = 8;
        drive();
        step(1'b1, 1'b1);
        check_outputs_zero("midreset");
        take_snap();
        waited = 0;
        step(1'b1, 1'b0);
        while (!plot && waited < 10) begin
            step(1'b1, 1'b0);
            waited++;
        end
        check("restart_plot", plot, 1);
        check("restart_x", x, 0);
        check("restart_y", y, 0);
        check("restart_fstart", frame_start, 1);
        check("restart_colour", colour, ref_colour(0, 0));
        for (int k = 1; k < 40; k++) begin
            step(1'b1, 1'b0);
            check("restart_seq_x", x, k);
            check("restart_seq_colour", colour, ref_colour(k, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
